led_intf: RTL and testbench

LED front-end of the doorlock: it turns a 2-bit status code from the lock controller into 8-LED display patterns. The patterns are off, steady on, blink and running chase. It runs on the 10 Hz system tick clock and sits between the lock FSM and the board's LED bank. All state is registered; `led_o` is decoded from registered state only, so it is glitch-free with respect to `led_sig_i`.

---
 rtl/led_intf.sv | 72 +++++++
 tb/tb_led_intf.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/led_intf.sv
// Doorlock LED front-end: maps the lock status code
// to off / steady / blink / chase patterns on 8 LEDs.
module led_intf #(
  parameter int BLINK_HALF = 5
) (
  input  logic       clk_10hz_i,
  input  logic       rst_i,
  input  logic [1:0] led_sig_i,
  output logic [1:8] led_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPEN  = 2'd1,
    ERROR = 2'd2,
    ALARM = 2'd3
  } mode_t;

  // 5 bits so the phase reaches 2*15-1 at the top of the legal range
  localparam int CW = 5;
  localparam logic [CW-1:0] CNT_MAX = CW'(2 * BLINK_HALF - 1);
  localparam logic [CW-1:0] HALF    = CW'(BLINK_HALF);
  localparam logic [7:0]    CHASE0  = 8'b1000_0000;

  mode_t           r_mode;
  mode_t           w_mode_nxt;
  mode_t           w_sig;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [7:0]      r_chase;
  logic [7:0]      w_chase_nxt;

  assign w_sig = mode_t'(led_sig_i);

  always_ff @(posedge clk_10hz_i or negedge rst_i) begin
    if (!rst_i) begin
      r_mode  <= IDLE;
      r_cnt   <= '0;
      r_chase <= CHASE0;
    end else begin
      r_mode  <= w_mode_nxt;
      r_cnt   <= w_cnt_nxt;
      r_chase <= w_chase_nxt;
    end
  end

  always_comb begin
    w_mode_nxt  = r_mode;
    w_cnt_nxt   = r_cnt;
    w_chase_nxt = r_chase;
    if (w_sig != r_mode) begin
      w_mode_nxt  = w_sig;
      w_cnt_nxt   = '0;
      w_chase_nxt = CHASE0;
    end else begin
      w_cnt_nxt   = (r_cnt == CNT_MAX) ? '0 : r_cnt + 1'b1;
      w_chase_nxt = {r_chase[0], r_chase[7:1]};
    end
  end

  always_comb begin
    led_o = '0;
    unique case (r_mode)
      IDLE:  led_o = 8'h00;
      OPEN:  led_o = 8'hFF;
      ERROR: led_o = (r_cnt < HALF) ? 8'hFF : 8'h00;
      ALARM: led_o = r_chase;
      default: led_o = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_led_intf.sv
// Bench for led_intf: directed vectors with literal
// expectations plus a per-cycle check against a pattern model.
module tb_led_intf;

  localparam int BH = 5;

  logic       clk;
  logic       rst_n;
  logic [1:0] sig;
  logic [1:8] led;

  led_intf #(.BLINK_HALF(BH)) dut (
    .clk_10hz_i(clk),
    .rst_i     (rst_n),
    .led_sig_i (sig),
    .led_o     (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit run    = 1'b0;

  // Model: current status and edges spent in it since entry
  int m_mode = 0;
  int m_age  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0;
      m_age  = 0;
    end else if (int'(sig) != m_mode) begin
      m_mode = int'(sig);
      m_age  = 0;
    end else begin
      m_age = m_age + 1;
    end
  end

  function automatic logic [7:0] model_led();
    logic [7:0] v;
    case (m_mode)
      1: v = 8'hFF;
      2: v = ((m_age % (2 * BH)) < BH) ? 8'hFF : 8'h00;
      3: v = 8'h80 >> (m_age % 8);
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (run) chk("model", led, model_led());
  end

  // Drive code, take one edge, check the literal expectation
  task automatic cyc(input logic [1:0] s, input logic [7:0] exp,
                     input string nm);
    sig = s;
    @(posedge clk);
    #1;
    chk(nm, led, exp);
  endtask

  logic [7:0] chase_tab [10];
  logic [7:0] e;

  initial begin
    chase_tab = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08,
                  8'h04, 8'h02, 8'h01, 8'h80, 8'h40};
    rst_n = 1'b0;
    sig   = 2'd0;
    run   = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset", led, 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc(2'd0, 8'h00, "idle");

    for (int i = 0; i < 20; i++) cyc(2'd1, 8'hFF, "open");

    for (int i = 0; i < 25; i++) begin
      e = ((i / 5) % 2 == 0) ? 8'hFF : 8'h00;
      cyc(2'd2, e, "blink");
    end
    for (int i = 0; i < 3; i++) cyc(2'd2, 8'h00, "blink_off");
    cyc(2'd1, 8'hFF, "err_open");
    cyc(2'd2, 8'hFF, "err_restart0");
    cyc(2'd2, 8'hFF, "err_restart1");

    for (int i = 0; i < 10; i++) cyc(2'd3, chase_tab[i], "chase");
    cyc(2'd1, 8'hFF, "chase_to_open");

    cyc(2'd0, 8'h00, "seq0a");
    cyc(2'd0, 8'h00, "seq0b");
    cyc(2'd1, 8'hFF, "seq1a");
    cyc(2'd1, 8'hFF, "seq1b");
    cyc(2'd2, 8'hFF, "seq2a");
    cyc(2'd2, 8'hFF, "seq2b");
    cyc(2'd3, 8'h80, "seq3a");
    cyc(2'd3, 8'h40, "seq3b");
    cyc(2'd1, 8'hFF, "seq1c");
    cyc(2'd1, 8'hFF, "seq1d");

    for (int i = 0; i < 4; i++) begin
      cyc(2'd2, 8'hFF, "tog_err");
      cyc(2'd3, 8'h80, "tog_alarm");
    end
    cyc(2'd2, 8'hFF, "alarm_to_err");
    cyc(2'd3, 8'h80, "err_to_alarm");
    cyc(2'd3, 8'h40, "alarm_run0");
    cyc(2'd3, 8'h20, "alarm_run1");

    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", led, 8'h00);
    @(posedge clk);
    #1;
    chk("reset_hold", led, 8'h00);
    rst_n = 1'b1;
    cyc(2'd3, 8'h80, "post_reset0");
    cyc(2'd3, 8'h40, "post_reset1");
    cyc(2'd3, 8'h20, "post_reset2");

    @(negedge clk);
    #1;
    run = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
